// File: rtl/local_bias_pkg.sv
// Shared types, supply constants and the window-compare helper for the
// local bias sequencer.
`ifndef wrealZState
`define wrealZState 1.23456789e+300
`endif

package local_bias_pkg;

  // Sequencer states; the encoding is visible on the state output.
  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RAMP  = 2'd1,
    ON    = 2'd2,
    FAULT = 2'd3
  } bias_state_e;

  localparam real VDD1P8_NOM = 1.8;
  localparam real VDD0P8_NOM = 0.8;
  localparam real VSS_WIN    = 0.05;

  // High-impedance marker for real-valued nets.
  localparam real WREAL_Z = `wrealZState;

  // Guard band so that bounds computed as nominal*(1+-tol) still accept a
  // supply value written with the same decimal digits.
  localparam real WIN_EPS = 1.0e-9;

  // Inclusive window compare.
  function automatic logic in_window(real v, real lo, real hi);
    return (v >= lo - WIN_EPS) && (v <= hi + WIN_EPS);
  endfunction

endpackage

// File: rtl/local_bias_supply_mon.sv
// Supply window monitor: combinational rail checks, symmetric debounce of
// the combined result, and one warning per loss of the supplies.
module local_bias_supply_mon
  import local_bias_pkg::*;
#(
  parameter int  DEB_CYC = 4,
  parameter real TOL     = 0.05
) (
  input  logic clk,
  input  logic rst_n,
  input  real  vddana_1p8,
  input  real  vddana_0p8,
  input  real  vssana,
  output logic ok_q
);

  localparam int CNT_W = $clog2(DEB_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

  logic ok_1p8;
  logic ok_0p8;
  logic ok_vss;
  logic supply_ok;
  logic sok_q;
  logic ok_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign ok_1p8 = in_window(vddana_1p8, VDD1P8_NOM * (1.0 - TOL), VDD1P8_NOM * (1.0 + TOL));
  assign ok_0p8 = in_window(vddana_0p8, VDD0P8_NOM * (1.0 - TOL), VDD0P8_NOM * (1.0 + TOL));
  assign ok_vss = in_window(vssana, -VSS_WIN, VSS_WIN);
  assign supply_ok = ok_1p8 && ok_0p8 && ok_vss;

  // Count consecutive samples disagreeing with ok_q; flip after DEB_CYC of them.
  always_comb begin
    ok_d  = ok_q;
    cnt_d = '0;
    if (supply_ok != ok_q) begin
      if (cnt_q == CNT_LAST) begin
        ok_d = supply_ok;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      ok_q  <= ok_d;
      cnt_q <= cnt_d;
    end
  end

  // Name each out-of-window rail once, on the falling edge of supply_ok.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sok_q <= 1'b1;
    end else begin
      sok_q <= supply_ok;
      if (sok_q && !supply_ok) begin
        if (!ok_1p8) $warning("local_bias_supply_mon: vddana_1p8 out of window at %f V", vddana_1p8);
        if (!ok_0p8) $warning("local_bias_supply_mon: vddana_0p8 out of window at %f V", vddana_0p8);
        if (!ok_vss) $warning("local_bias_supply_mon: vssana out of window at %f V", vssana);
      end
    end
  end

endmodule

// File: rtl/local_bias_seq.sv
// NCH-channel programmable bias generator. Channels power up one slot at a
// time once the supplies are debounced good; a supply loss while biasing
// latches FAULT until pdb is dropped. A registered test bus can observe
// either supply or any channel current.
module local_bias_seq
  import local_bias_pkg::*;
#(
  parameter int  NCH        = 4,
  parameter int  CODE_W     = 10,
  parameter real ILSB       = 1.0e-6,
  parameter int  SETTLE_CYC = 8,
  parameter int  DEB_CYC    = 4,
  parameter real TOL        = 0.05,
  parameter int  SEL_W      = $clog2(NCH + 2)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pdb,
  input  real                        vddana_1p8,
  input  real                        vddana_0p8,
  input  real                        vssana,
  input  logic [NCH-1:0][CODE_W-1:0] ch_code,
  input  logic [NCH-1:0]             ch_en,
  input  logic                       atb_ena,
  input  logic [SEL_W-1:0]           atb_sel,
  output real                        ibias [NCH],
  output real                        atb1,
  output real                        atb0,
  output logic                       bias_ready,
  output logic                       fault,
  output logic [1:0]                 state
);

  // Slot NCH is the extra settle period after the last channel.
  localparam int SLOT_W = $clog2(NCH + 2);
  localparam int CYC_W  = $clog2(SETTLE_CYC + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NCH);
  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(SETTLE_CYC - 1);

  logic              ok_q;
  bias_state_e       state_q;
  logic [NCH-1:0]    en_q;
  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] slot_inc;
  logic [CYC_W-1:0]  cyc_q;
  logic              ready_q;
  logic              fault_q;
  real               ibias_q [NCH];
  real               atb1_q;
  real               atb0_q;

  function automatic real code_to_amp(input logic [CODE_W-1:0] code);
    return real'(code) * ILSB;
  endfunction

  local_bias_supply_mon #(
    .DEB_CYC (DEB_CYC),
    .TOL     (TOL)
  ) u_supply_mon (
    .clk        (clk),
    .rst_n      (rst_n),
    .vddana_1p8 (vddana_1p8),
    .vddana_0p8 (vddana_0p8),
    .vssana     (vssana),
    .ok_q       (ok_q)
  );

  assign slot_inc = slot_q + SLOT_W'(1);

  // Sequencer: power-up slots, ready/fault flags and channel currents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      en_q    <= '0;
      slot_q  <= '0;
      cyc_q   <= '0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      for (int k = 0; k < NCH; k++) ibias_q[k] <= WREAL_Z;
    end else if (!pdb) begin
      // Power-down overrides everything, including a concurrent fault.
      state_q <= OFF;
      slot_q  <= '0;
      cyc_q   <= '0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      for (int k = 0; k < NCH; k++) ibias_q[k] <= WREAL_Z;
    end else begin
      case (state_q)
        OFF: begin
          if (ok_q) begin
            state_q <= RAMP;
            en_q    <= ch_en;
            slot_q  <= '0;
            cyc_q   <= '0;
            // Slot 0 starts on the entry edge.
            if (ch_en[0]) ibias_q[0] <= code_to_amp(ch_code[0]);
          end
        end
        RAMP: begin
          if (!ok_q) begin
            state_q <= FAULT;
            fault_q <= 1'b1;
            ready_q <= 1'b0;
            for (int k = 0; k < NCH; k++) ibias_q[k] <= WREAL_Z;
          end else if (cyc_q == CYC_LAST) begin
            cyc_q <= '0;
            if (slot_q == SLOT_LAST) begin
              state_q <= ON;
              ready_q <= 1'b1;
              for (int k = 0; k < NCH; k++)
                ibias_q[k] <= en_q[k] ? code_to_amp(ch_code[k]) : WREAL_Z;
            end else begin
              slot_q <= slot_inc;
              for (int k = 0; k < NCH; k++)
                if (en_q[k] && (SLOT_W'(k) == slot_inc)) ibias_q[k] <= code_to_amp(ch_code[k]);
            end
          end else begin
            cyc_q <= cyc_q + CYC_W'(1);
          end
        end
        ON: begin
          if (!ok_q) begin
            state_q <= FAULT;
            fault_q <= 1'b1;
            ready_q <= 1'b0;
            for (int k = 0; k < NCH; k++) ibias_q[k] <= WREAL_Z;
          end else begin
            for (int k = 0; k < NCH; k++)
              ibias_q[k] <= en_q[k] ? code_to_amp(ch_code[k]) : WREAL_Z;
          end
        end
        default: begin
          // FAULT is left only through pdb=0.
          state_q <= FAULT;
        end
      endcase
    end
  end

  // Test bus mux, registered; sources are the live supplies and channel currents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      atb1_q <= WREAL_Z;
      atb0_q <= WREAL_Z;
    end else if (atb_ena && (state_q != OFF)) begin
      atb1_q <= WREAL_Z;
      atb0_q <= vssana;
      if (atb_sel == SEL_W'(0)) begin
        atb1_q <= vddana_1p8;
      end else if (atb_sel == SEL_W'(1)) begin
        atb1_q <= vddana_0p8;
      end else if (int'(atb_sel) <= NCH + 1) begin
        for (int k = 0; k < NCH; k++)
          if (int'(atb_sel) == k + 2) atb1_q <= ibias_q[k];
      end else begin
        atb0_q <= WREAL_Z;
      end
    end else begin
      atb1_q <= WREAL_Z;
      atb0_q <= WREAL_Z;
    end
  end

  assign ibias      = ibias_q;
  assign atb1       = atb1_q;
  assign atb0       = atb0_q;
  assign bias_ready = ready_q;
  assign fault      = fault_q;
  assign state      = state_q;

endmodule

// File: tb/tb_local_bias_seq.sv
// Self-checking bench for local_bias_seq. Cycle index c counts clock edges
// after the edge at which reset is released with pdb=1 and good supplies
// (first such edge is c=0).
module tb_local_bias_seq;
  import local_bias_pkg::*;

  localparam int  NCH        = 4;
  localparam int  CODE_W     = 10;
  localparam real ILSB       = 1.0e-6;
  localparam int  SETTLE_CYC = 8;
  localparam int  DEB_CYC    = 4;
  localparam int  SEL_W      = $clog2(NCH + 2);
  localparam int  RAMP_LEN   = (NCH + 1) * SETTLE_CYC;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b1;
  logic                       pdb = 1'b0;
  real                        v18 = 1.8;
  real                        v08 = 0.8;
  real                        vss = 0.0;
  logic [NCH-1:0][CODE_W-1:0] ch_code = '0;
  logic [NCH-1:0]             ch_en = '0;
  logic                       atb_ena = 1'b0;
  logic [SEL_W-1:0]           atb_sel = '0;
  real                        ibias [NCH];
  real                        atb1;
  real                        atb0;
  logic                       bias_ready;
  logic                       fault;
  logic [1:0]                 state;

  int             errors = 0;
  int             checks = 0;
  int             code_v [NCH];
  logic [NCH-1:0] en_lat = '0;

  local_bias_seq #(
    .NCH(NCH), .CODE_W(CODE_W), .ILSB(ILSB), .SETTLE_CYC(SETTLE_CYC),
    .DEB_CYC(DEB_CYC), .TOL(0.05), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pdb(pdb),
    .vddana_1p8(v18), .vddana_0p8(v08), .vssana(vss),
    .ch_code(ch_code), .ch_en(ch_en),
    .atb_ena(atb_ena), .atb_sel(atb_sel),
    .ibias(ibias), .atb1(atb1), .atb0(atb0),
    .bias_ready(bias_ready), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_code(input int k, input int val);
    code_v[k]  = val;
    ch_code[k] = CODE_W'(val);
  endtask

  function automatic real amp(input int k);
    return real'(code_v[k]) * ILSB;
  endfunction

  // Release reset with nominal supplies and pdb=1 in the phase after an edge.
  task automatic restart(input logic [NCH-1:0] mask);
    rst_n = 1'b0; v18 = 1.8; v08 = 0.8; vss = 0.0; pdb = 1'b1;
    atb_ena = 1'b0; ch_en = mask;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    pdb = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (bias_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bias_ready); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
    checks++; if (atb1 != WREAL_Z || atb0 != WREAL_Z) begin errors++; $display("FAIL reset_atb: got %g/%g want Z", atb1, atb0); end
    for (int k = 0; k < NCH; k++) begin
      checks++; if (ibias[k] != WREAL_Z) begin errors++; $display("FAIL reset_ibias[%0d]: got %g want Z", k, ibias[k]); end
    end
    step();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_hold_state: got %0d want 0", state); end
  endtask

  task automatic test_ramp(input logic [NCH-1:0] mask);
    bias_state_e es;
    real         ei;
    restart(mask);
    en_lat = mask;
    for (int c = 0; c < DEB_CYC + RAMP_LEN + 3; c++) begin
      step();
      es = (c < DEB_CYC) ? OFF : (c < DEB_CYC + RAMP_LEN) ? RAMP : ON;
      checks++; if (state !== es) begin errors++; $display("FAIL ramp_state c=%0d: got %0d want %0d", c, state, es); end
      checks++; if (bias_ready !== (c >= DEB_CYC + RAMP_LEN)) begin errors++; $display("FAIL ramp_ready c=%0d: got %b", c, bias_ready); end
      for (int k = 0; k < NCH; k++) begin
        ei = (mask[k] && c >= DEB_CYC + k * SETTLE_CYC) ? amp(k) : WREAL_Z;
        checks++; if (ibias[k] != ei) begin errors++; $display("FAIL ramp_ibias[%0d] c=%0d: got %g want %g", k, c, ibias[k], ei); end
      end
      // The enable mask is latched at RAMP entry; later changes must not matter.
      if (c == DEB_CYC + 1) ch_en = ~mask;
    end
  endtask

  task automatic test_atb();
    int  sels [9];
    real e1, e0, p1, p0;
    sels = '{0, 1, 3, 6, 2, 5, 4, 7, 0};
    vss = 0.02;
    atb_ena = 1'b1;
    p1 = WREAL_Z; p0 = WREAL_Z;
    atb_sel = '0;
    step();
    for (int i = 0; i < 9; i++) begin
      atb_sel = SEL_W'(sels[i]);
      if (i > 0) begin
        #1;
        checks++; if (atb1 != p1 || atb0 != p0) begin errors++; $display("FAIL atb_hold sel=%0d: got %g/%g want %g/%g", sels[i], atb1, atb0, p1, p0); end
      end
      step();
      if (sels[i] == 0) begin e1 = v18; e0 = vss; end
      else if (sels[i] == 1) begin e1 = v08; e0 = vss; end
      else if (sels[i] <= NCH + 1) begin e1 = en_lat[sels[i]-2] ? amp(sels[i] - 2) : WREAL_Z; e0 = vss; end
      else begin e1 = WREAL_Z; e0 = WREAL_Z; end
      checks++; if (atb1 != e1 || atb0 != e0) begin errors++; $display("FAIL atb_sel%0d: got %g/%g want %g/%g", sels[i], atb1, atb0, e1, e0); end
      p1 = e1; p0 = e0;
    end
    atb_ena = 1'b0;
    step();
    checks++; if (atb1 != WREAL_Z || atb0 != WREAL_Z) begin errors++; $display("FAIL atb_disabled: got %g/%g want Z", atb1, atb0); end
    vss = 0.0;
  endtask

  task automatic test_on_tracking();
    real ei;
    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < NCH; k++)
        set_code(k, (i % 6 == 0) ? 0 : (i % 6 == 1) ? 1023 : int'($urandom_range(0, 1023)));
      ch_en = NCH'($urandom);
      step();
      checks++; if (state !== ON || bias_ready !== 1'b1) begin errors++; $display("FAIL on_state i=%0d: got %0d/%b want 2/1", i, state, bias_ready); end
      for (int k = 0; k < NCH; k++) begin
        ei = en_lat[k] ? amp(k) : WREAL_Z;
        checks++; if (ibias[k] != ei) begin errors++; $display("FAIL on_track[%0d] i=%0d: got %g want %g", k, i, ibias[k], ei); end
      end
    end
  endtask

  task automatic test_fault();
    bias_state_e es;
    // A dip shorter than the debounce is filtered.
    v08 = 0.70;
    repeat (DEB_CYC - 1) step();
    v08 = 0.8;
    repeat (3) step();
    checks++; if (state !== ON || fault !== 1'b0) begin errors++; $display("FAIL short_dip: got state=%0d fault=%b want 2/0", state, fault); end
    // A dip of DEB_CYC samples drops ok, and the next edge enters FAULT.
    v08 = 0.70;
    for (int i = 1; i <= DEB_CYC + 1; i++) begin
      step();
      es = (i == DEB_CYC + 1) ? FAULT : ON;
      checks++; if (state !== es) begin errors++; $display("FAIL long_dip i=%0d: got %0d want %0d", i, state, es); end
    end
    checks++; if (fault !== 1'b1 || bias_ready !== 1'b0) begin errors++; $display("FAIL fault_flags: got fault=%b ready=%b want 1/0", fault, bias_ready); end
    for (int k = 0; k < NCH; k++) begin
      checks++; if (ibias[k] != WREAL_Z) begin errors++; $display("FAIL fault_ibias[%0d]: got %g want Z", k, ibias[k]); end
    end
    // Recovery of the supply does not clear the fault.
    v08 = 0.8;
    repeat (10) step();
    checks++; if (state !== FAULT || fault !== 1'b1) begin errors++; $display("FAIL fault_sticky: got state=%0d fault=%b want 3/1", state, fault); end
    pdb = 1'b0;
    step();
    checks++; if (state !== OFF || fault !== 1'b0) begin errors++; $display("FAIL fault_clear: got state=%0d fault=%b want 0/0", state, fault); end
    ch_en = '1;
    en_lat = '1;
    pdb = 1'b1;
    step();
    checks++; if (state !== RAMP || ibias[0] != amp(0)) begin errors++; $display("FAIL reramp: got state=%0d ibias0=%g want 1/%g", state, ibias[0], amp(0)); end
    repeat (RAMP_LEN) step();
    checks++; if (state !== ON) begin errors++; $display("FAIL reramp_on: got %0d want 2", state); end
    // pdb=0 on the same edge the fault would be taken.
    v08 = 0.70;
    repeat (DEB_CYC) step();
    checks++; if (state !== ON) begin errors++; $display("FAIL pre_race: got %0d want 2", state); end
    pdb = 1'b0;
    step();
    checks++; if (state !== OFF || fault !== 1'b0) begin errors++; $display("FAIL pdb_wins: got state=%0d fault=%b want 0/0", state, fault); end
    v08 = 0.8;
    pdb = 1'b1;
  endtask

  task automatic test_window();
    real w18 [11];
    real w08 [11];
    real wss [11];
    bit  acc [11];
    bias_state_e es;
    w18 = '{1.71, 1.89, 1.70, 1.90, 1.8,  1.8,  1.8,  1.8,  1.8,   1.8,  1.8};
    w08 = '{0.8,  0.8,  0.8,  0.8,  0.76, 0.84, 0.70, 0.8,  0.8,   0.8,  0.8};
    wss = '{0.0,  0.0,  0.0,  0.0,  0.0,  0.0,  0.0,  0.05, -0.05, 0.06, -0.06};
    acc = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,  1'b0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      restart('1);
      v18 = w18[i]; v08 = w08[i]; vss = wss[i];
      repeat (DEB_CYC + 1) step();
      es = acc[i] ? RAMP : OFF;
      checks++; if (state !== es) begin errors++; $display("FAIL window%0d (%g,%g,%g): got %0d want %0d", i, w18[i], w08[i], wss[i], state, es); end
    end
    v18 = 1.8; v08 = 0.8; vss = 0.0;
  endtask

  task automatic test_reset_mid_ramp();
    bias_state_e es;
    restart('1);
    en_lat = '1;
    atb_ena = 1'b1;
    atb_sel = '0;
    repeat (DEB_CYC + 2 * SETTLE_CYC + 1) step();
    checks++; if (state !== RAMP || ibias[2] != amp(2) || ibias[3] != WREAL_Z) begin errors++; $display("FAIL slot2: got state=%0d ib2=%g ib3=%g", state, ibias[2], ibias[3]); end
    checks++; if (atb1 != 1.8) begin errors++; $display("FAIL slot2_atb: got %g want 1.8", atb1); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (state !== OFF || bias_ready !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL async_reset: got state=%0d ready=%b fault=%b", state, bias_ready, fault); end
    checks++; if (atb1 != WREAL_Z || atb0 != WREAL_Z) begin errors++; $display("FAIL async_reset_atb: got %g/%g want Z", atb1, atb0); end
    for (int k = 0; k < NCH; k++) begin
      checks++; if (ibias[k] != WREAL_Z) begin errors++; $display("FAIL async_reset_ibias[%0d]: got %g want Z", k, ibias[k]); end
    end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < DEB_CYC + 2; c++) begin
      step();
      es = (c < DEB_CYC) ? OFF : RAMP;
      checks++; if (state !== es) begin errors++; $display("FAIL restart c=%0d: got %0d want %0d", c, state, es); end
    end
    atb_ena = 1'b0;
  endtask

  initial begin
    test_reset();
    set_code(0, 25); set_code(1, 25); set_code(2, 500); set_code(3, 500);
    test_ramp(4'b1111);
    test_atb();
    test_on_tracking();
    test_fault();
    test_window();
    for (int k = 0; k < NCH; k++) set_code(k, int'($urandom_range(0, 1023)));
    test_ramp(4'b0101);
    for (int k = 0; k < NCH; k++) set_code(k, int'($urandom_range(0, 1023)));
    test_ramp(NCH'($urandom));
    test_reset_mid_ramp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/local_bias_seq.md
Name: local_bias_seq

Overview:
Parametrised successor of the fixed four-output local bias generator. It provides NCH programmable bias-current channels. Channels are powered up in a timed sequence after the supplies pass a debounced check, and a sticky fault state latches if a supply leaves its window while biasing. A generalised analog test bus (ATB) can route either supply, or any one channel current, onto atb1/atb0. The block is a clocked wreal model and sits where the single-shot bias block sat, feeding the clock-distribution, latch and DAC bias inputs.

Parameters:
NCH, 4, number of bias channels (1..16)
CODE_W, 10, width of each channel current code
ILSB, 1.0e-6, amps per code LSB (real)
SETTLE_CYC, 8, clk cycles between successive channel enables, and after the last channel before ready (>=1)
DEB_CYC, 4, consecutive cycles a supply condition must persist to be accepted (>=1)
TOL, 0.05, relative tolerance for the 1p8/0p8 windows; vssana window is ±0.05 V absolute
SEL_W, $clog2(NCH+2), width of atb_sel

Ports:
clk  in  1  model clock
rst_n  in  1  asynchronous active-low reset
pdb  in  1  power-down bar; 0 forces OFF and clears fault
vddana_1p8  in  real  1.8 V supply
vddana_0p8  in  real  0.8 V supply
vssana  in  real  ground
ch_code  in  [NCH][CODE_W]  per-channel current code
ch_en  in  NCH  per-channel enable mask, sampled on entry to RAMP
atb_ena  in  1  test bus enable
atb_sel  in  SEL_W  test bus source select
ibias  out  real[NCH]  channel currents
atb1  out  real  test bus high
atb0  out  real  test bus low
bias_ready  out  1  all enabled channels settled
fault  out  1  sticky supply fault
state  out  2  FSM state for observation

Behaviour:
- Reset, asynchronous: state=OFF; ibias[*], atb1 and atb0 = `wrealZState; bias_ready=0; fault=0; all counters cleared. Reset mid-RAMP or mid-ON gives the same result immediately.
- supply_ok (combinational): 1p8 within [1.8*(1-TOL), 1.8*(1+TOL)], 0p8 within [0.8*(1-TOL), 0.8*(1+TOL)], vssana within [-0.05, 0.05]. All bounds are inclusive.
- Debounce: ok_q rises after DEB_CYC consecutive clk edges with supply_ok=1. It falls after DEB_CYC consecutive edges with supply_ok=0. Any opposite sample resets the count.
- FSM states: OFF=0, RAMP=1, ON=2, FAULT=3.
- OFF: all outputs Z. Go to RAMP when pdb=1 and ok_q=1. Latch ch_en into en_q on that edge.
- RAMP: slot counter k = 0..NCH-1 with SETTLE_CYC cycles per slot. At the start of slot k, if en_q[k]=1, ibias[k] = ch_code[k]*ILSB. Channels not in en_q stay Z. After the last slot plus one extra SETTLE_CYC, go to ON. Total RAMP duration is (NCH+1)*SETTLE_CYC cycles.
- ON: bias_ready=1. Each enabled ibias tracks ch_code with 1-cycle latency. Code 0 gives 0.0 A, not Z. ch_en changes are ignored until the next RAMP.
- RAMP/ON to FAULT when ok_q falls. In FAULT: fault=1, bias_ready=0, all ibias Z.
- FAULT is sticky: it exits to OFF only when pdb=0. Supplies recovering does not clear it.
- pdb=0 in any state: next edge goes to OFF, bias_ready=0, ibias Z, fault cleared. If pdb=0 and the fault condition occur on the same edge, pdb wins.
- $warning once per transition of supply_ok to 0, naming each failing rail and its value. No per-cycle spam.
- ATB, registered with 1-cycle latency, active only when atb_ena=1 and state != OFF; otherwise both outputs are Z.
  - sel 0: atb1=vddana_1p8, atb0=vssana.
  - sel 1: atb1=vddana_0p8, atb0=vssana.
  - sel 2..NCH+1: atb1=ibias[sel-2], atb0=vssana.
  - sel > NCH+1: both Z.
- Arithmetic: the code is unsigned and converted to real before multiplying by ILSB. No saturation is needed.

Decomposition:
- Package local_bias_pkg holds:
  - the bias_state_e enum (OFF, RAMP, ON, FAULT);
  - the VDD1P8_NOM, VDD0P8_NOM and VSS_WIN constants;
  - the in_window(real v, real lo, real hi) function.
- Sub-module local_bias_supply_mon contains the window compare, the DEB_CYC debounce counter and the warning, and outputs ok_q. The sequencer FSM and the ATB mux stay in the top module.

Test Plan:
1. Nominal supplies, pdb=1, ch_en=4'b1111, codes {25,25,500,500}: ibias[k] goes non-Z at cycle 4+8k after pdb. bias_ready=1 at cycle 4+40. Values are 25e-6, 25e-6, 500e-6, 500e-6.
2. ch_en=4'b0101: ibias[1] and ibias[3] stay Z throughout. RAMP still lasts 40 cycles.
3. In ON, drop 0p8 to 0.70 V for 3 cycles, then restore: no fault. Drop it for 4 cycles: FAULT, all ibias Z. Restore 0p8: remains FAULT until pdb pulses 0, then OFF and re-ramp.
4. 1p8 at exactly 1.71 V and 1.89 V: accepted. 1p8 at 1.70 V: rejected, warning printed once.
5. atb_ena=1 in ON, sel=0,1,3,6: atb1 = 1.8 V, 0.8 V, 25e-6 (ibias[1]), then Z/Z, each one cycle after the sel change.
6. rst_n asserted mid-RAMP at slot 2: all outputs Z and state=OFF immediately. After release, the sequence restarts from the debounce stage.
